// File: rtl/ucsbece154_imem_burst_responder.sv
// Purpose : memory-side responder that answers an icache refill request with a BLOCK_WORDS-beat burst.
// Latency : beat 0 FIRST_LATENCY cycles after capture, later beats every WORD_GAP cycles; outputs registered.
// Backpr. : none; the requester holds MemReadRequest for the burst, and dropping it early aborts the burst.
//
// Ports:
//   Clk, Reset_n                 clock and synchronous active-low reset
//   MemReadRequest/Address       level-held refill request and byte address (address sampled at capture)
//   MemDataIn/MemDataReady       beat data and one-cycle beat strobe (data is 0 between beats)
//   Busy                         high from capture through the cycle of the last beat
//   BurstCount/AbortCount        wrapping counts of completed and aborted bursts
module ucsbece154_imem_burst_responder #(
   parameter int          BLOCK_WORDS   = 4,
   parameter int          MEM_WORDS     = 1024,
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter int          FIRST_LATENCY = 3,
   parameter int          WORD_GAP      = 1,
   parameter              MEM_FILE      = ""
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        MemReadRequest,
   input  logic [31:0] MemReadAddress,
   output logic [31:0] MemDataIn,
   output logic        MemDataReady,
   output logic        Busy,
   output logic [15:0] BurstCount,
   output logic [15:0] AbortCount
);

   localparam int OFF_W   = $clog2(BLOCK_WORDS) + 2;
   localparam int IDX_W   = $clog2(MEM_WORDS);
   localparam int BEAT_W  = $clog2(BLOCK_WORDS);
   localparam int MAX_CNT = (FIRST_LATENCY > WORD_GAP) ? FIRST_LATENCY : WORD_GAP;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_DONE} state_t;

   logic [31:0] r_mem [MEM_WORDS] = '{default: '0};

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [BEAT_W-1:0]  r_beat, w_beat_nxt;
   logic               r_busy, w_busy_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [31:0]        r_dat;
   logic               r_rdy;
   logic [15:0]        r_burst_cnt, r_abort_cnt;
   logic               w_capture, w_emit, w_last, w_abort;

   // Block-aligned base, rebased to the array; only the low index bits are kept so addresses wrap.
   logic [31:0]        w_base, w_off;
   logic [IDX_W-1:0]   w_idx, w_rd_idx;
   logic               w_unused;

   assign w_base   = {MemReadAddress[31:OFF_W], {OFF_W{1'b0}}};
   assign w_off    = w_base - BASE_ADDR;
   assign w_idx    = w_off[IDX_W+1:2];
   assign w_rd_idx = r_idx + IDX_W'(r_beat);
   assign w_unused = ^{w_off[31:IDX_W+2], w_off[1:0], MemReadAddress[OFF_W-1:0]};

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_beat  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_beat  <= w_beat_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // WAIT and BEAT share one path: r_cnt counts down to the next beat in both,
   // and beat 0 can never be the last beat because BLOCK_WORDS >= 2.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_beat_nxt  = r_beat;
      w_busy_nxt  = r_busy;
      w_capture   = 1'b0;
      w_emit      = 1'b0;
      w_last      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (MemReadRequest) begin
               w_capture   = 1'b1;
               w_busy_nxt  = 1'b1;
               w_cnt_nxt   = CNT_W'(FIRST_LATENCY - 1);
               w_beat_nxt  = '0;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT, S_BEAT: begin
            if (!MemReadRequest) begin
               w_abort     = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == '0) begin
               w_emit    = 1'b1;
               w_cnt_nxt = CNT_W'(WORD_GAP - 1);
               if (r_beat == LAST_BEAT) begin
                  w_last      = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_beat_nxt  = r_beat + BEAT_W'(1);
                  w_state_nxt = S_BEAT;
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_DONE: begin
            // Busy drops the cycle after the last beat; a still-high request is the old one.
            w_busy_nxt = 1'b0;
            if (!MemReadRequest) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_idx       <= '0;
         r_dat       <= '0;
         r_rdy       <= 1'b0;
         r_burst_cnt <= '0;
         r_abort_cnt <= '0;
      end else begin
         if (w_capture) begin
            r_idx <= w_idx;
         end
         r_rdy <= w_emit;
         r_dat <= w_emit ? r_mem[w_rd_idx] : 32'h0;
         if (w_last) begin
            r_burst_cnt <= r_burst_cnt + 16'd1;
         end
         if (w_abort) begin
            r_abort_cnt <= r_abort_cnt + 16'd1;
         end
      end
   end

   assign MemDataIn    = r_dat;
   assign MemDataReady = r_rdy;
   assign Busy         = r_busy;
   assign BurstCount   = r_burst_cnt;
   assign AbortCount   = r_abort_cnt;

endmodule

// File: tb/tb_ucsbece154_imem_burst_responder.sv
// Purpose : bench for ucsbece154_imem_burst_responder; two instances with different timing share one stimulus.
// Latency : reference model predicts beat times as capture + FIRST_LATENCY + k*WORD_GAP.
// Backpr. : requester model holds, drops early, or lingers after the burst at random.
module tb_ucsbece154_imem_burst_responder;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        MemReadRequest;
   logic [31:0] MemReadAddress;

   logic [31:0] a_dat, b_dat;
   logic        a_rdy, b_rdy, a_busy, b_busy;
   logic [15:0] a_bc, a_ac, b_bc, b_ac;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 Clk = ~Clk;

   ucsbece154_imem_burst_responder #(
      .BLOCK_WORDS(4), .MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000),
      .FIRST_LATENCY(3), .WORD_GAP(1), .MEM_FILE("")
   ) u_dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .MemReadRequest(MemReadRequest), .MemReadAddress(MemReadAddress),
      .MemDataIn(a_dat), .MemDataReady(a_rdy), .Busy(a_busy), .BurstCount(a_bc), .AbortCount(a_ac)
   );

   ucsbece154_imem_burst_responder #(
      .BLOCK_WORDS(8), .MEM_WORDS(256), .BASE_ADDR(32'h0000_0100),
      .FIRST_LATENCY(1), .WORD_GAP(3), .MEM_FILE("")
   ) u_dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .MemReadRequest(MemReadRequest), .MemReadAddress(MemReadAddress),
      .MemDataIn(b_dat), .MemDataReady(b_rdy), .Busy(b_busy), .BurstCount(b_bc), .AbortCount(b_ac)
   );

   // Instance parameters, indexed 0 = u_dut_a, 1 = u_dut_b.
   function automatic int p_bw(input int n);  return (n == 0) ? 4 : 8;    endfunction
   function automatic int p_mw(input int n);  return (n == 0) ? 1024 : 256; endfunction
   function automatic int p_fl(input int n);  return (n == 0) ? 3 : 1;    endfunction
   function automatic int p_gap(input int n); return (n == 0) ? 1 : 3;    endfunction
   function automatic logic [31:0] p_base(input int n);
      return (n == 0) ? 32'h0 : 32'h100;
   endfunction

   logic [31:0] tb_mem [1024];

   // Reference model: a burst is "active" from capture until its last beat; "armed" means
   // the request has been seen low since the previous completed burst.
   bit          m_active [2];
   bit          m_armed  [2];
   int          m_cap    [2];
   logic [31:0] m_idx    [2];
   logic        e_rdy    [2];
   logic [31:0] e_dat    [2];
   logic        e_busy   [2];
   logic [15:0] e_bc     [2];
   logic [15:0] e_ac     [2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_step(input int n);
      int          d;
      int          k;
      logic [31:0] base;
      if (!Reset_n) begin
         m_active[n] = 0; m_armed[n] = 1;
         e_rdy[n] = 0; e_dat[n] = 0; e_busy[n] = 0; e_bc[n] = 0; e_ac[n] = 0;
      end else if (m_active[n]) begin
         e_rdy[n] = 0; e_dat[n] = 0;
         d = cyc - m_cap[n] - p_fl(n);
         if (!MemReadRequest) begin
            m_active[n] = 0; m_armed[n] = 1; e_busy[n] = 0; e_ac[n] = e_ac[n] + 16'd1;
         end else if (d >= 0 && (d % p_gap(n)) == 0) begin
            k = d / p_gap(n);
            e_rdy[n] = 1;
            e_dat[n] = tb_mem[(m_idx[n] + k) % p_mw(n)];
            if (k == p_bw(n) - 1) begin
               e_bc[n] = e_bc[n] + 16'd1;
               m_active[n] = 0; m_armed[n] = 0;
            end
         end
      end else begin
         e_rdy[n] = 0; e_dat[n] = 0; e_busy[n] = 0;
         if (!m_armed[n]) begin
            if (!MemReadRequest) m_armed[n] = 1;
         end else if (MemReadRequest) begin
            base = MemReadAddress & ~(32'(p_bw(n) * 4) - 32'd1);
            m_idx[n] = ((base - p_base(n)) >> 2) % p_mw(n);
            m_cap[n] = cyc; m_active[n] = 1; e_busy[n] = 1;
         end
      end
   endtask

   // Called at a falling edge: drive inputs, advance the model, clock once, compare.
   task automatic step(input logic rst_v, input logic req_v, input logic [31:0] addr_v);
      Reset_n = rst_v; MemReadRequest = req_v; MemReadAddress = addr_v;
      model_step(0);
      model_step(1);
      @(posedge Clk);
      @(negedge Clk);
      check_eq("a.rdy",  {31'b0, a_rdy},  {31'b0, e_rdy[0]});
      check_eq("a.dat",  a_dat,           e_dat[0]);
      check_eq("a.busy", {31'b0, a_busy}, {31'b0, e_busy[0]});
      check_eq("a.bcnt", {16'b0, a_bc},   {16'b0, e_bc[0]});
      check_eq("a.acnt", {16'b0, a_ac},   {16'b0, e_ac[0]});
      check_eq("b.rdy",  {31'b0, b_rdy},  {31'b0, e_rdy[1]});
      check_eq("b.dat",  b_dat,           e_dat[1]);
      check_eq("b.busy", {31'b0, b_busy}, {31'b0, e_busy[1]});
      check_eq("b.bcnt", {16'b0, b_bc},   {16'b0, e_bc[1]});
      check_eq("b.acnt", {16'b0, b_ac},   {16'b0, e_ac[1]});
      cyc++;
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0014;
         1:       return 32'h0000_0FF8;
         2:       return 32'h0000_1000;
         3:       return 32'h0000_00F4;
         4:       return 32'h0000_0500 + 32'($urandom_range(0, 63));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      logic        req_r;
      logic [31:0] addr_r;
      Reset_n = 1'b0; MemReadRequest = 1'b0; MemReadAddress = 32'h0;
      #1;
      for (int i = 0; i < 1024; i++) begin
         tb_mem[i] = 32'h1000_0000 + 32'(i);
         u_dut_a.r_mem[i] = tb_mem[i];
         if (i < 256) u_dut_b.r_mem[i] = tb_mem[i];
      end
      @(negedge Clk);

      // Reset, then the documented scenarios in sequence.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
      // Burst at 0x14, held three cycles past the last beat, then low for one cycle.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'h14);
      step(1'b1, 1'b0, 32'h0);
      // Second burst at 0xFF8 (wraps to the end of the array); address wiggles while busy.
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, (i == 0) ? 32'hFF8 : 32'h0000_0ABC);
      step(1'b1, 1'b0, 32'h0);
      // Abort right after beat 1, then a fresh request two cycles later.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h14);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 32'h1000);
      step(1'b1, 1'b0, 32'h0);
      // Reset in the middle of a burst with the request still high.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h20);
      step(1'b0, 1'b1, 32'h20);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 32'h40);
      step(1'b1, 1'b0, 32'h0);

      // Randomized requester.
      req_r = 1'b0; addr_r = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         if (req_r) begin
            if (!m_active[0] && !m_armed[0]) req_r = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 24) == 0) req_r = 1'b0;
            if ($urandom_range(0, 3) == 0) addr_r = $urandom();
         end else if ($urandom_range(0, 2) == 0) begin
            req_r = 1'b1;
            addr_r = pick_addr();
         end
         step(($urandom_range(0, 299) != 0), req_r, addr_r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
